// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for jk_excite_driver.
// JK codes are packed as {j, k}.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // True when a {j,k} code changes the flop state
  function automatic logic jk_active(input logic [1:0] c);
    return c != JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation map from current to next state.
// JK_TOGGLE_EXCITE_EN selects toggle excitation for changing bits.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q_cur,
  input  logic q_next,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  // Pick the {j,k} code that moves q_cur to q_next
  always_comb begin
    jk = JK_HOLD;
`ifdef JK_TOGGLE_EXCITE_EN
    if (q_cur != q_next) begin
      jk = JK_TGL;
    end
`else
    unique case ({q_cur, q_next})
      2'b01:   jk = JK_SET;
      2'b10:   jk = JK_CLR;
      default: jk = JK_HOLD;
    endcase
`endif
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flop bank to target words and checks feedback.
// Optional macro JK_TOGGLE_EXCITE_EN: toggle excitation.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tgt_valid,
  input  logic [W-1:0]  tgt_data,
  output logic          tgt_ready,
  output logic [W-1:0]  j,
  output logic [W-1:0]  k,
  input  logic [W-1:0]  q_fb,
  input  logic          err_clr,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state_q, state_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [W-1:0]  j_q, j_d;
  logic [W-1:0]  k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  exc_j;
  logic [W-1:0]  exc_k;
  logic          in_idle;
  logic          in_check;
  logic          accept;
  logic          mismatch;

  // Excitation is formed at accept time so j/k are
  // registered and valid for the whole DRIVE cycle
  for (genvar i = 0; i < W; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q_cur  (shadow_q[i]),
      .q_next (tgt_data[i]),
      .j      (exc_j[i]),
      .k      (exc_k[i])
    );
  end

  assign in_idle  = (state_q == IDLE);
  assign in_check = (state_q == CHECK);
  assign accept   = in_idle & tgt_valid;
  assign mismatch = in_check & (q_fb != tgt_q);

  // Next-state, excitation and error count
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tgt_d    = tgt_q;
    j_d      = '0;
    k_d      = '0;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        shadow_d = q_fb;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_clr) begin
      cnt_d = '0;
    end else if (mismatch && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tgt_ready = in_idle;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = in_check;
  assign err       = mismatch;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Testbench for jk_excite_driver with a JK bank model.
// Transaction-level reference model and directed checks.
module tb_jk_excite_driver;

`ifdef JK_TOGGLE_EXCITE_EN
  localparam bit TGL = 1'b1;
`else
  localparam bit TGL = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       tgt_ready;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q_fb;
  logic       err_clr;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;

  logic [3:0] bank;
  logic [3:0] stuck;

  int n_chk;
  int n_fail;

  jk_excite_driver #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: q+ = j&~q | ~k&q
  always @(posedge clk or posedge reset) begin
    if (reset) bank <= 4'b0000;
    else bank <= (j & ~bank) | (~k & bank);
  end

  assign q_fb = bank | stuck;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // {j,k} needed to move state s to target t
  function automatic logic [7:0] excite(logic [3:0] s,
                                         logic [3:0] t);
    if (TGL) return {s ^ t, s ^ t};
    return {t & ~s, s & ~t};
  endfunction

  // Reference model: age of the current transaction
  int         m_age;
  logic [3:0] m_tgt;
  logic [3:0] m_sh;
  int         m_cnt;

  initial begin
    logic [7:0] ex;
    logic       e_done;
    logic       e_err;
    int         n_cnt;
    m_age = 0; m_tgt = 0; m_sh = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_age = 0; m_tgt = 0; m_sh = 0; m_cnt = 0;
      end
      ex = excite(m_sh, m_tgt);
      e_done = (m_age == 2);
      e_err = e_done && (q_fb != m_tgt);
      check("m_ready", 32'(tgt_ready), 32'(m_age == 0));
      check("m_j", 32'(j),
            32'(m_age == 1 ? ex[7:4] : 4'b0));
      check("m_k", 32'(k),
            32'(m_age == 1 ? ex[3:0] : 4'b0));
      check("m_done", 32'(done), 32'(e_done));
      check("m_err", 32'(err), 32'(e_err));
      check("m_cnt", 32'(err_cnt), 32'(m_cnt));
      if (!reset) begin
        if (err_clr) n_cnt = 0;
        else if (e_err && m_cnt < 255) n_cnt = m_cnt + 1;
        else n_cnt = m_cnt;
        m_cnt = n_cnt;
        if (m_age == 0) begin
          if (tgt_valid) begin
            m_age = 1;
            m_tgt = tgt_data;
          end
        end else if (m_age == 1) begin
          m_age = 2;
        end else begin
          m_sh = q_fb;
          m_age = 0;
        end
      end
    end
  end

  // One full transaction; captures DRIVE j/k and CHECK flags
  task automatic xact(input logic [3:0] t,
                      input bit clr,
                      output logic [3:0] cj,
                      output logic [3:0] ck,
                      output logic cd,
                      output logic ce);
    int w;
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_data = t;
    err_clr = clr;
    w = 0;
    @(negedge clk);
    while (!tgt_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 32'(tgt_ready), 32'd1);
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    tgt_data = 4'($urandom);
    @(negedge clk);
    cj = j;
    ck = k;
    @(posedge clk); #1;
    @(negedge clk);
    cd = done;
    ce = err;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] cj, ck;
    logic       cd, ce;
    logic [3:0] seq [3];
    int         idx, last, dones;

    reset = 1'b1;
    tgt_valid = 1'b0;
    tgt_data = 4'b0;
    err_clr = 1'b0;
    stuck = 4'b0;
    n_chk = 0;
    n_fail = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(tgt_ready), 32'd1);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 0000 -> 1010
    xact(4'b1010, 0, cj, ck, cd, ce);
    check("t1_j", 32'(cj), 32'b1010);
    check("t1_k", 32'(ck), TGL ? 32'b1010 : 32'b0000);
    check("t1_done", 32'(cd), 32'd1);
    check("t1_err", 32'(ce), 32'd0);
    @(negedge clk);
    check("t1_ready_back", 32'(tgt_ready), 32'd1);

    // 1010 -> 0110
    xact(4'b0110, 0, cj, ck, cd, ce);
    check("t2_j", 32'(cj), TGL ? 32'b1100 : 32'b0100);
    check("t2_k", 32'(ck), TGL ? 32'b1100 : 32'b1000);
    check("t2_err", 32'(ce), 32'd0);
    check("t2_qfb", 32'(q_fb), 32'b0110);

    // bit0 stuck at 1: 0110 -> 0000 mismatches
    stuck = 4'b0001;
    xact(4'b0000, 0, cj, ck, cd, ce);
    check("t3_j", 32'(cj), TGL ? 32'b0110 : 32'b0000);
    check("t3_k", 32'(ck), 32'b0110);
    check("t3_err", 32'(ce), 32'd1);
    @(negedge clk);
    check("t3_cnt", 32'(err_cnt), 32'd1);

    // shadow is now 0001, so this target needs no drive
    xact(4'b0001, 0, cj, ck, cd, ce);
    check("t4_j", 32'(cj), 32'd0);
    check("t4_k", 32'(ck), 32'd0);
    check("t4_done", 32'(cd), 32'd1);
    check("t4_err", 32'(ce), 32'd0);

    // saturate the counter
    for (int n = 0; n < 254; n++)
      xact(4'b0000, 0, cj, ck, cd, ce);
    @(negedge clk);
    check("sat_255", 32'(err_cnt), 32'd255);
    xact(4'b0000, 0, cj, ck, cd, ce);
    check("sat_err", 32'(ce), 32'd1);
    @(negedge clk);
    check("sat_hold", 32'(err_cnt), 32'd255);

    // clear from IDLE
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_idle", 32'(err_cnt), 32'd0);

    // clear coincident with an error: clear wins
    xact(4'b0000, 1, cj, ck, cd, ce);
    check("clr_err", 32'(ce), 32'd1);
    @(negedge clk);
    check("clr_cnt", 32'(err_cnt), 32'd0);

    // reset in DRIVE (shadow is 0001)
    stuck = 4'b0000;
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_data = 4'b1111;
    @(negedge clk);
    check("rd_ready", 32'(tgt_ready), 32'd1);
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("rd_j", 32'(j), 32'b1110);
    check("rd_k", 32'(k), TGL ? 32'b1110 : 32'b0000);
    reset = 1'b1;
    #1;
    check("rd_j0", 32'(j), 32'd0);
    check("rd_k0", 32'(k), 32'd0);
    check("rd_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rd_ready_rel", 32'(tgt_ready), 32'd1);
    xact(4'b0000, 0, cj, ck, cd, ce);
    check("rd_sh_j", 32'(cj), 32'd0);
    check("rd_sh_k", 32'(ck), 32'd0);
    check("rd_sh_err", 32'(ce), 32'd0);

    // back-to-back with tgt_valid held
    seq[0] = 4'b0001;
    seq[1] = 4'b0011;
    seq[2] = 4'b0111;
    idx = 0;
    last = 0;
    dones = 0;
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_data = seq[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done) dones++;
      if (tgt_ready && idx < 3) begin
        if (idx > 0)
          check("b2b_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        idx++;
        @(posedge clk); #1;
        if (idx < 3) tgt_data = seq[idx];
        else tgt_valid = 1'b0;
      end
    end
    check("b2b_accepts", 32'(idx), 32'd3);
    check("b2b_dones", 32'(dones), 32'd3);
    check("b2b_qfb", 32'(q_fb), 32'b0111);
    check("b2b_cnt", 32'(err_cnt), 32'd0);

    // randomized traffic, faults, clears and resets
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      tgt_valid = 1'($urandom_range(0, 1));
      tgt_data = 4'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0)
        stuck = 4'($urandom) & 4'($urandom);
      reset = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tgt_valid = 1'b0;
    err_clr = 1'b0;
    stuck = 4'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
- Drives a W-bit bank of synchronous JK flip-flops (q resets to 0; JK=00 hold, 01 clear, 10 set, 11 toggle) to requested target values.
- Accepts target words over a valid/ready handshake and derives per-bit J/K excitation from a shadow copy of the bank state.
- Pulses J/K for one cycle, then checks the bank's q feedback and counts mismatches.
- Sits between a control sequencer and the JK register bank.

Parameters:
- W, 4, width of the target word and of the JK bank.
- CW, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tgt_valid  in  1  target word valid.
- tgt_data  in  W  requested next state of the JK bank.
- tgt_ready  out  1  driver can accept a target.
- j  out  W  J inputs to the JK bank.
- k  out  W  K inputs to the JK bank.
- q_fb  in  W  q outputs fed back from the JK bank.
- err_clr  in  1  synchronous clear of err_cnt.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse, coincident with done, on feedback mismatch.
- err_cnt  out  CW  saturating count of mismatched transactions.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, shadow=0, tgt_reg=0, j=0, k=0, done=0, err=0, err_cnt=0, tgt_ready=1 once reset deasserts.
- Shadow resets to 0 to match the bank's reset value.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1, j=k=0.
  - On tgt_valid & tgt_ready: latch tgt_data into tgt_reg, go to DRIVE.
- DRIVE (exactly 1 cycle):
  - tgt_ready=0.
  - j/k are registered outputs computed per bit from (shadow[i], tgt_reg[i]):
    - 0->0: J=0, K=0.
    - 0->1: J=1, K=0.
    - 1->0: J=0, K=1.
    - 1->1: J=0, K=0.
  - Don't-cares always resolve to 0.
  - The bank samples J/K at the end of this cycle. Go to CHECK.
- CHECK (exactly 1 cycle):
  - j=k=0. Compare q_fb with tgt_reg.
  - Pulse done=1.
  - If q_fb != tgt_reg: pulse err=1 and increment err_cnt, saturating at 2^CW-1.
  - Shadow <= q_fb (resynchronise to actual bank state, not tgt_reg). Go to IDLE.
- Latency: accept-to-done = 2 cycles; throughput is 1 target per 3 cycles.
- tgt_data is ignored whenever tgt_ready=0. tgt_valid may stay high; the next word is accepted on re-entry to IDLE.
- err_clr:
  - Zeroes err_cnt on the next edge.
  - When coincident with a CHECK-cycle error, clear wins (err still pulses, count stays 0).
- Target equal to shadow: DRIVE outputs j=k=0, and the transaction still completes with done.
- Reset mid-DRIVE or mid-CHECK: immediate return to IDLE with outputs at reset values.
  - No done or err is produced for the aborted word.
  - The bank must be reset in the same cycle so shadow=0 stays valid.

Optional Feature:
- Macro: JK_TOGGLE_EXCITE_EN.
- Defined: bits that change state use toggle excitation, J=1 and K=1, for both 0->1 and 1->0. Unchanged bits still use J=K=0.
- Not defined: set/clear excitation as specified above.
- FSM, latency and check behaviour are identical in both builds.
- Toggle mode makes a shadow/bank desync visible as err, because a toggle inverts the bank's actual state rather than forcing it.

Decomposition:
- Package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK);
  - 2-bit JK code constants JK_HOLD=00, JK_CLR=01, JK_SET=10, JK_TGL=11.
- One natural sub-module: jk_excite_bit, a combinational map of (q_cur, q_next) to {j, k} containing the macro selection. It is instantiated W times via generate.

Test Plan (W=4, bench instantiates a W-wide JK bank with feedback):
- Reset, then tgt_data=4'b1010 -> DRIVE cycle j=1010, k=0000; CHECK q_fb=1010; done=1, err=0; tgt_ready back at 1 three cycles after accept.
- From 1010, tgt_data=4'b0110 -> j=0100, k=1000 (with JK_TOGGLE_EXCITE_EN: j=k=1100); q_fb=0110, err=0.
- Force q_fb bit0 stuck at 1, tgt_data=4'b0000 from 0110 -> err=1, err_cnt 0->1; shadow becomes 0001.
- Preload err_cnt to 255 via repeated errors (CW=8), one more error -> err_cnt stays 255; then err_cln=1 -> err_cnt=0 next cycle.
- Assert reset during DRIVE -> j=k=0 immediately, no done, tgt_ready=1 after reset release, shadow=0.
- Hold tgt_valid high with targets 0001, 0011, 0111 back-to-back -> accepts spaced 3 cycles apart, three done pulses, final q_fb=0111, err_cnt=0.
